// File: rtl/uart_rx_deserializer.sv
// UART receiver: 2-flop synchronised rx_i, mid-bit sampling, start-glitch rejection, framing-error pulse.
// Latency: valid_o rises 3 + BAUD_DIV/2 + (DATA_WIDTH+1)*BAUD_DIV cycles after the rx_i falling edge (+BAUD_DIV with parity).
// No backpressure: valid_o/frame_err_o are one-cycle pulses; optional even parity via define UART_RX_PARITY_EN.
module uart_rx_deserializer #(
   parameter int DATA_WIDTH = 8,
   parameter int BAUD_DIV   = 868
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  en_i,
   input  logic                  rx_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   output logic                  frame_err_o,
   output logic                  busy_o
`ifdef UART_RX_PARITY_EN
   ,output logic                 parity_err_o
`endif
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam int BW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] HALF_M1  = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] BAUD_M1  = CW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
      PARITY    = 3'd3,
`endif
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5
   } state_t;

   state_t                  state_q, state_d;
   logic                    rx_meta_q, rx_s_q;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
   logic                    par_bit_q, par_bit_d;
   logic                    parity_err_q, parity_err_d;
`endif

   // Two-flop synchroniser for the asynchronous line; resets to the idle (high) level.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
      end
   end

   // State, counters, shift register and output pulse registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
         par_bit_q    <= par_bit_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   // Next-state logic: the baud counter counts down and every state acts when it reaches zero.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_d    = par_bit_q;
      parity_err_d = 1'b0;
`endif
      if (!en_i) begin
         // Disable aborts any frame silently, including one waiting for the line to recover.
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (!rx_s_q) begin
                  state_d = START;
                  cnt_d   = HALF_M1;
               end
            end
            START: begin
               if (cnt_q == '0) begin
                  if (!rx_s_q) begin
                     state_d   = DATA;
                     cnt_d     = BAUD_M1;
                     bit_cnt_d = '0;
                  end else begin
                     // Line went high again before mid start bit: treat as a glitch.
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            DATA: begin
               if (cnt_q == '0) begin
                  shift_d[bit_cnt_q] = rx_s_q;
                  cnt_d              = BAUD_M1;
                  if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end else begin
                     bit_cnt_d = bit_cnt_q + BW'(1);
                  end
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt_q == '0) begin
                  par_bit_d = rx_s_q;
                  cnt_d     = BAUD_M1;
                  state_d   = STOP;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
`endif
            STOP: begin
               if (cnt_q == '0) begin
                  if (rx_s_q) begin
                     state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                     if ((^shift_q) ^ par_bit_q) begin
                        parity_err_d = 1'b1;
                     end else begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                     end
`else
                     valid_d = 1'b1;
                     data_d  = shift_q;
`endif
                  end else begin
                     // Low stop bit: report and wait for the line to recover so a break
                     // cannot be mistaken for a stream of start bits.
                     frame_err_d = 1'b1;
                     state_d     = WAIT_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            WAIT_IDLE: begin
               if (rx_s_q) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign frame_err_o = frame_err_q;
   assign busy_o      = (state_q != IDLE) && (state_q != WAIT_IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomised + directed bench for uart_rx_deserializer with a queue-based scoreboard.
// Expected events (data / framing error / parity error, and the cycle they are due) are pushed per frame.
// A negedge monitor pops and compares whenever the DUT pulses an output.
module tb_uart_rx_deserializer;

   localparam int DW   = 8;
   localparam int BD   = 16;
   localparam int HALF = BD / 2;
`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   // Falling edge at cycle c -> pulse visible in cycle c + 2 (sync) + 1 + HALF + (DW+1+PB)*BD.
   localparam int LAT = 3 + HALF + (DW + 1 + PB) * BD;

   logic          clk = 1'b0;
   logic          rstn;
   logic          en_i;
   logic          rx_i;
   logic [DW-1:0] data_o;
   logic          valid_o;
   logic          frame_err_o;
   logic          busy_o;
   logic          par_err;

   typedef struct {
      int         kind;   // 0 = data word, 1 = framing error, 2 = parity error
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t       sb_q[$];
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] last_good = 8'h00;
   logic [7:0] held_data = 8'h00;

`ifdef UART_RX_PARITY_EN
   logic parity_err_o;
   assign par_err = parity_err_o;
`else
   assign par_err = 1'b0;
`endif

   uart_rx_deserializer #(.DATA_WIDTH(DW), .BAUD_DIV(BD)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .en_i        (en_i),
      .rx_i        (rx_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .frame_err_o (frame_err_o),
      .busy_o      (busy_o)
`ifdef UART_RX_PARITY_EN
      ,.parity_err_o (parity_err_o)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every pulse must match the head of the scoreboard; data_o must hold otherwise.
   always @(negedge clk) begin
      exp_t e;
      int   kind;
      if (rstn !== 1'b1) begin
         held_data = 8'h00;
      end else if (valid_o || frame_err_o || par_err) begin
         kind = valid_o ? 0 : (frame_err_o ? 1 : 2);
         check("one_event_per_cycle", 32'(valid_o) + 32'(frame_err_o) + 32'(par_err), 1);
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: kind %0d data 0x%0h at cycle %0d, none expected", kind, data_o, cyc);
         end else begin
            e = sb_q.pop_front();
            check("event_kind", kind, e.kind);
            if (e.kind == 0) begin
               check("data_o_word", 32'(data_o), 32'(e.data));
               held_data = e.data;
            end
            n_checks++;
            if (cyc < e.cyc - 1 || cyc > e.cyc + 1) begin
               n_fail++;
               $display("FAIL event_latency: pulse at cycle %0d, expected %0d +/-1", cyc, e.cyc);
            end
         end
      end else begin
         check("data_o_hold", 32'(data_o), 32'(held_data));
      end
   end

   // Hold the line at v for n cycles; starts and ends just after a rising edge.
   task automatic drive(input logic v, input int n);
      rx_i = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Full frame; the expected outcome follows from the stop bit and the even-parity rule.
   task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop);
      exp_t e;
      logic par;
      par    = (^d) ^ ~par_ok;
      e.data = d;
      e.cyc  = cyc + LAT;
      if (!stop)                     e.kind = 1;
      else if (PB == 1 && !par_ok)   e.kind = 2;
      else begin
         e.kind    = 0;
         last_good = d;
      end
      sb_q.push_back(e);
      drive(1'b0, BD);
      for (int i = 0; i < DW; i++) drive(d[i], BD);
      if (PB == 1) drive(par, BD);
      drive(stop, BD);
   endtask

   // Start bit plus the first nbits data bits only (frame to be aborted by the caller).
   task automatic send_partial(input logic [7:0] d, input int nbits);
      drive(1'b0, BD);
      for (int i = 0; i < nbits; i++) drive(d[i], BD);
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && sb_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d expected events never seen", sb_q.size());
         sb_q.delete();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] d;
      logic       stop;
      logic       pok;
      int         gap;

      rstn = 1'b0;
      en_i = 1'b1;
      rx_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_data_o", 32'(data_o), 0);
      check("rst_valid_o", 32'(valid_o), 0);
      check("rst_frame_err_o", 32'(frame_err_o), 0);
      check("rst_busy_o", 32'(busy_o), 0);
      check("rst_parity_err", 32'(par_err), 0);
      rstn = 1'b1;
      drive(1'b1, 5);

      // Basic word.
      send_frame(8'hA5, 1'b1, 1'b1);
      drive(1'b1, 10);
      wait_drain(400);
      check("a5_busy_after", 32'(busy_o), 0);
      check("a5_data_o", 32'(data_o), 32'h A5);

      // Start glitch shorter than half a bit.
      drive(1'b0, 3);
      drive(1'b1, 30);
      check("glitch_busy", 32'(busy_o), 0);
      check("glitch_data_o", 32'(data_o), 32'h A5);

      // Framing error followed by a break: no new frame until the line recovers.
      send_frame(8'h3C, 1'b1, 1'b0);
      drive(1'b0, 40);
      check("break_busy", 32'(busy_o), 0);
      check("break_data_o", 32'(data_o), 32'h A5);
      drive(1'b1, 20);
      wait_drain(400);
      send_frame(8'h5A, 1'b1, 1'b1);
      drive(1'b1, 10);
      wait_drain(400);
      check("after_break_data_o", 32'(data_o), 32'h5A);

      // Back-to-back frames with no idle gap.
      send_frame(8'h00, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1);
      drive(1'b1, 10);
      wait_drain(400);
      check("b2b_data_o", 32'(data_o), 32'hFF);

      // Reset in the middle of a frame.
      send_partial(8'h66, 4);
      rstn = 1'b0;
      #1;
      check("midrst_data_o", 32'(data_o), 0);
      check("midrst_valid_o", 32'(valid_o), 0);
      check("midrst_frame_err_o", 32'(frame_err_o), 0);
      check("midrst_busy_o", 32'(busy_o), 0);
      last_good = 8'h00;
      rx_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      drive(1'b1, 5);
      send_frame(8'h81, 1'b1, 1'b1);
      drive(1'b1, 10);
      wait_drain(400);
      check("after_rst_data_o", 32'(data_o), 32'h81);

      // Enable dropped mid-frame: silent abort.
      send_partial(8'hC3, 3);
      en_i = 1'b0;
      drive(1'b1, 3);
      check("en_drop_busy", 32'(busy_o), 0);
      en_i = 1'b1;
      drive(1'b1, 10);
      check("en_drop_data_o", 32'(data_o), 32'h81);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h03, 1'b1, 1'b1);
      drive(1'b1, 10);
      send_frame(8'h03, 1'b0, 1'b1);
      drive(1'b1, 10);
      wait_drain(400);
      check("parity_data_o", 32'(data_o), 32'h03);
`endif

      // Random frames: mostly good, some framing errors, random gaps (including zero).
      for (int k = 0; k < 24; k++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 5) != 0);
         pok  = ($urandom_range(0, 3) != 0);
         gap  = stop ? $urandom_range(0, 12) : $urandom_range(4, 12);
         send_frame(d, pok, stop);
         if (gap > 0) drive(1'b1, gap);
      end
      drive(1'b1, 20);
      wait_drain(800);
      check("final_data_o", 32'(data_o), 32'(last_good));
      check("final_busy_o", 32'(busy_o), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
